// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM port and the IF/ID pipeline register.
// Handles stall, flush with a new PC, and branch redirect (including a branch seen during a stall).
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic              ce_r;
  logic [ADDR_W-1:0] pc;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_tgt;

  assign rom_ce     = ce_r;
  assign rom_addr_o = pc;

  // Program counter and the branch remembered across a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_r     <= 1'b0;
      pc       <= RESET_PC;
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else if (!ce_r) begin
      ce_r <= 1'b1;
    end else if (flush_i) begin
      pc     <= new_pc_i;
      pend_v <= 1'b0;
    end else if (stall_i) begin
      if (branch_flag_i) begin
        pend_v   <= 1'b1;
        pend_tgt <= branch_target_i;
      end
    end else if (branch_flag_i) begin
      pc     <= branch_target_i;
      pend_v <= 1'b0;
    end else if (pend_v) begin
      pc     <= pend_tgt;
      pend_v <= 1'b0;
    end else begin
      pc <= pc + STEP;
    end
  end

  // IF/ID register; the word fetched in a branch cycle is the delay slot and is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else if (flush_i || !ce_r) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      id_pc_o    <= pc;
      id_inst_o  <= rom_data_i;
      id_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, branch_flag_i;
  logic [31:0] new_pc_i, branch_target_i;
  logic        rom_ce;
  logic [31:0] rom_addr_o, rom_data_i, id_pc_o, id_inst_o;
  logic        id_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .rom_ce(rom_ce), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
  );

  // ROM contents: word i at byte address 4*i holds 0x1000_0000+i.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (32'h1000_0000 + {2'b00, a[31:2]}) ^ {a[1:0], 30'd0};
  endfunction

  assign rom_data_i = rom(rom_addr_o);

  // Behavioural model: what fetches next and what decode currently holds.
  logic        m_started;
  logic [31:0] m_fetch;
  logic        m_have_pending;
  logic [31:0] m_pending;
  logic [31:0] m_id_pc, m_id_inst;
  logic        m_id_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_fetch = 0; m_have_pending = 0; m_pending = 0;
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    end else if (!m_started) begin
      m_started = 1;
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    end else if (flush_i) begin
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
      m_fetch = new_pc_i; m_have_pending = 0;
    end else if (stall_i) begin
      if (branch_flag_i) begin m_have_pending = 1; m_pending = branch_target_i; end
    end else begin
      m_id_pc = m_fetch; m_id_inst = rom(m_fetch); m_id_valid = 1;
      if (branch_flag_i) m_fetch = branch_target_i;
      else if (m_have_pending) m_fetch = m_pending;
      else m_fetch = m_fetch + 32'd4;
      m_have_pending = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_rom_ce", {31'd0, rom_ce}, {31'd0, m_started});
    chk("m_rom_addr", rom_addr_o, m_fetch);
    chk("m_id_pc", id_pc_o, m_id_pc);
    chk("m_id_inst", id_inst_o, m_id_inst);
    chk("m_id_valid", {31'd0, id_valid_o}, {31'd0, m_id_valid});
    if (id_valid_o === 1'b1) chk("m_inst_matches_pc", id_inst_o, rom(id_pc_o));
  end

  task automatic step(input logic s, input logic f, input logic [31:0] np,
                      input logic b, input logic [31:0] bt);
    stall_i = s; flush_i = f; new_pc_i = np; branch_flag_i = b; branch_target_i = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 0; flush_i = 0; new_pc_i = 0; branch_flag_i = 0; branch_target_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", {31'd0, rom_ce}, 32'd0);
    chk("rst_addr", rom_addr_o, 32'd0);
    chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
    rst = 1'b0;
    chk("start_addr0", rom_addr_o, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("start_addr1", rom_addr_o, 32'h0);
    chk("start_ce", {31'd0, rom_ce}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("start_addr2", rom_addr_o, 32'h4);
    chk("start_inst0", id_inst_o, 32'h1000_0000);
    chk("start_valid", {31'd0, id_valid_o}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("start_addr3", rom_addr_o, 32'h8);
    chk("start_inst1", id_inst_o, 32'h1000_0001);

    // Branch with delay slot
    step(0, 0, 0, 1, 32'h40);
    chk("br_slot_pc", id_pc_o, 32'h8);
    chk("br_addr", rom_addr_o, 32'h40);
    step(0, 0, 0, 0, 0);
    chk("br_id_pc", id_pc_o, 32'h40);

    // Stall three cycles at pc 0x10 with a branch in stall cycle 2
    step(0, 1, 32'hC, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("st_pre_addr", rom_addr_o, 32'h10);
    step(1, 0, 0, 0, 0);
    chk("st1_addr", rom_addr_o, 32'h10);
    step(1, 0, 0, 1, 32'h80);
    chk("st2_addr", rom_addr_o, 32'h10);
    chk("st2_id_pc", id_pc_o, 32'hC);
    step(1, 0, 0, 0, 0);
    chk("st3_addr", rom_addr_o, 32'h10);
    chk("st3_id_pc", id_pc_o, 32'hC);
    step(0, 0, 0, 0, 0);
    chk("st_post_addr", rom_addr_o, 32'h80);
    chk("st_post_id_pc", id_pc_o, 32'h10);

    // Flush overrides stall, branch and a pending branch
    step(1, 0, 0, 1, 32'h200);
    step(1, 1, 32'h180, 1, 32'h300);
    chk("fl_valid", {31'd0, id_valid_o}, 32'd0);
    chk("fl_inst", id_inst_o, 32'd0);
    chk("fl_addr", rom_addr_o, 32'h180);
    step(0, 0, 0, 0, 0);
    chk("fl_no_pend", rom_addr_o, 32'h184);

    // Address wrap-around
    step(0, 1, 32'hFFFF_FFF8, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wr_pre", rom_addr_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chk("wr_addr", rom_addr_o, 32'h0);
    chk("wr_id_pc", id_pc_o, 32'hFFFF_FFFC);

    // Reset while a branch is pending
    step(1, 0, 0, 1, 32'h400);
    #2 rst = 1'b1;
    #1;
    chk("mr_ce", {31'd0, rom_ce}, 32'd0);
    chk("mr_addr", rom_addr_o, 32'd0);
    chk("mr_valid", {31'd0, id_valid_o}, 32'd0);
    chk("mr_id_pc", id_pc_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mr_no_branch", rom_addr_o, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
           {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC,
           $urandom_range(0, 99) < 15,
           ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC));
    end
    rst = 1'b0;
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the Sirius core: owns the program counter, drives the instruction ROM port (`rom_ce`, address out, instruction in), and registers each fetched word with its PC into the IF/ID pipeline register that the decode stage consumes. It sits directly between the instruction ROM and decode inside the core. It handles pipeline stall, pipeline flush with a new PC, and branch redirect, including a branch that arrives during a stall. MIPS-style branch delay slot: the word fetched in the branch cycle is kept.

## Interface

- `ADDR_W`, 32, PC / ROM address width
- `INST_W`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset
- `PC_STEP`, 4, sequential PC increment

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `stall_i`  in  1  hold PC and IF/ID contents
- `flush_i`  in  1  discard IF/ID contents, redirect PC to `new_pc_i`
- `new_pc_i`  in  ADDR_W  flush target (exception vector / ERET address)
- `branch_flag_i`  in  1  decode requests redirect (1-cycle pulse)
- `branch_target_i`  in  ADDR_W  redirect target
- `rom_ce`  out  1  ROM enable
- `rom_addr_o`  out  ADDR_W  ROM address (= PC register)
- `rom_data_i`  in  INST_W  ROM data; combinational, valid in the same cycle as `rom_addr_o`
- `id_pc_o`  out  ADDR_W  PC of the word held in IF/ID
- `id_inst_o`  out  INST_W  instruction held in IF/ID
- `id_valid_o`  out  1  IF/ID holds a real instruction

## Operation

- **Registers:** `ce_r`, `pc`, `pend_v`, `pend_tgt`, and IF/ID (`id_pc_o`, `id_inst_o`, `id_valid_o`).
- **Reset values** (asynchronous): `rom_ce`=0, `pc`=`RESET_PC`, `pend_v`=0, `pend_tgt`=0, `id_pc_o`=0, `id_inst_o`=0, `id_valid_o`=0.
- **Start-up:** the first edge after `rst` deasserts sets `ce_r`=1 and leaves `pc` at `RESET_PC`. While `ce_r`=0, `pc` does not advance and IF/ID loads a bubble.
- **Outputs:** `rom_ce`=`ce_r`; `rom_addr_o`=`pc`.
- **PC next-state**, evaluated when `ce_r`=1, in priority order:
  1. `flush_i`: `pc`←`new_pc_i`; `pend_v`←0.
  2. `stall_i`: `pc` holds. If `branch_flag_i`=1, then `pend_v`←1 and `pend_tgt`←`branch_target_i`.
  3. `branch_flag_i`: `pc`←`branch_target_i`; `pend_v`←0.
  4. `pend_v`: `pc`←`pend_tgt`; `pend_v`←0.
  5. Otherwise: `pc`←`pc`+`PC_STEP`, modulo 2^ADDR_W. 0xFFFFFFFC wraps to 0x0.
- **IF/ID next-state**, in priority order:
  1. `rst` or `flush_i` or `ce_r`=0: bubble (pc=0, inst=0, valid=0).
  2. `stall_i`: hold all three fields.
  3. Otherwise: `id_pc_o`←`pc`, `id_inst_o`←`rom_data_i`, `id_valid_o`←1.
- **Delay slot:** on a branch cycle, IF/ID captures the word at the current `pc` (the delay slot). It is not squashed.
- **Simultaneous events:** `flush_i` overrides `stall_i`, `branch_flag_i` and any pending branch. A second branch during the same stall overwrites `pend_tgt`.
- **Alignment:** target low bits are passed through unmodified. Alignment checks belong to decode/exception logic.
- **Reset mid-operation:** all state returns to reset values immediately. A pending branch is lost.

## Timing

- **Fetch latency:** 1 cycle. The word at address p appears on `id_inst_o` on the edge that ends the cycle in which `rom_addr_o`=p.
- **Throughput:** one instruction per cycle when not stalled.
- **Branch redirect:** `branch_flag_i` high in cycle t gives `rom_addr_o`=target in cycle t+1 and `id_pc_o`=target in cycle t+2.
- **Branch during stall:** target is issued on the first cycle after `stall_i` falls.
- **Flush:** `flush_i` in cycle t gives `id_valid_o`=0 and `rom_addr_o`=`new_pc_i` in cycle t+1.
- **Stall:** `stall_i` is level-sensitive. No output changes while it is high, except that `pend_*` may be written.

## Test plan

- **Reset / start-up:** assert `rst` for 3 cycles, then release, with ROM word i = 0x1000_0000+i. Required: `rom_ce`=0 during reset; `rom_addr_o` = 0, 0, 4, 8 on successive cycles after release; `id_inst_o` = 0x1000_0000, 0x1000_0001 with `id_valid_o`=1.
- **Branch:** `branch_flag_i` pulse with target 0x40 while `pc`=0x8. Required: IF/ID captures PC 0x8 (delay slot); next `rom_addr_o`=0x40; following `id_pc_o`=0x40.
- **Stall with branch:** stall 3 cycles with `pc`=0x10, and pulse `branch_flag_i` (target 0x80) in stall cycle 2. Required: `rom_addr_o` and IF/ID hold for 3 cycles; first post-stall `rom_addr_o`=0x80.
- **Flush priority:** `flush_i`, `stall_i`, `branch_flag_i` all high with `new_pc_i`=0x180. Required: `id_valid_o`=0, `id_inst_o`=0, `rom_addr_o`=0x180, pending branch cleared.
- **Wrap-around:** `pc`=0xFFFF_FFFC, no stall. Required: next `rom_addr_o`=0x0000_0000, `id_pc_o`=0xFFFF_FFFC.
- **Reset mid-stall:** `rst` pulsed with `pend_v`=1. Required: immediate reset values; no branch issued after restart.
